plab4_net_sd_terminal: RTL and testbench

Endpoint terminal attached to one port of the time-multiplexed, security-domain ring network. Packs client send requests into network messages and injects them on the ring's `in_*` port with the terminal's fixed domain tag. Receives the ring's `out_*` messages only during the ring phase that belongs to its own domain, and buffers them for the client. Backpressure toward the ring never depends on other-domain state.

---
 rtl/plab4_net_sd_terminal_pkg.sv | 24 ++
 rtl/plab4_net_sd_rx_queue.sv | 57 +++++
 rtl/plab4_net_sd_terminal.sv | 132 +++++++++++++
 tb/tb_plab4_net_sd_terminal.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_sd_terminal_pkg.sv
// plab4_net_sd_terminal_pkg: net message layout helpers shared by the SD terminal files
package plab4_net_sd_terminal_pkg;

    // Total width of a net message {dest, src, opaque, payload}
    function automatic int net_msg_nbits(input int p, input int o, input int s);
        return p + o + 2 * s;
    endfunction

    // LSB of the src field; opaque starts at bit p, payload at bit 0
    function automatic int net_msg_src_lsb(input int p, input int o);
        return p + o;
    endfunction

    // LSB of the dest field, which occupies the top s bits
    function automatic int net_msg_dest_lsb(input int p, input int o, input int s);
        return p + o + s;
    endfunction

    // Pointer width for a power-of-two queue depth
    function automatic int ptr_nbits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/plab4_net_sd_rx_queue.sv
// plab4_net_sd_rx_queue: power-of-two depth FIFO with asynchronous active-low reset
module plab4_net_sd_rx_queue
    import plab4_net_sd_terminal_pkg::*;
#(
    parameter int p_nbits = 38,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val_i,
    input  logic [p_nbits-1:0] enq_data_i,
    input  logic               deq_rdy_i,
    output logic [p_nbits-1:0] deq_data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int AW = ptr_nbits(p_depth);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [p_nbits-1:0] mem_q [p_depth];
    logic             enq, deq;

    assign full_o     = cnt_q == CW'(p_depth);
    assign empty_o    = cnt_q == '0;
    assign enq        = enq_val_i & !full_o;
    assign deq        = deq_rdy_i & !empty_o;
    assign deq_data_o = mem_q[rd_q];

    // Pointers wrap naturally; enqueue plus dequeue leaves the count alone
    always_comb begin
        wr_d  = wr_q + AW'(enq);
        rd_d  = rd_q + AW'(deq);
        cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end

    // Control state is the only thing reset clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is never reset; entries are meaningful only while counted
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_q] <= enq_data_i;
    end

endmodule

// File: rtl/plab4_net_sd_terminal.sv
// plab4_net_sd_terminal: security-domain ring endpoint; TX register, phase-gated RX queue.
// Optional stats counters: define PLAB4_NET_SD_TERMINAL_STATS_EN.
module plab4_net_sd_terminal
    import plab4_net_sd_terminal_pkg::*;
#(
    parameter int   p_payload_nbits = 32,
    parameter int   p_opaque_nbits  = 3,
    parameter int   p_srcdest_nbits = 3,
    parameter int   p_term_id       = 0,
    parameter logic p_sd            = 1'b0,
    parameter int   p_rx_depth      = 2,
    localparam int  P = p_payload_nbits,
    localparam int  O = p_opaque_nbits,
    localparam int  S = p_srcdest_nbits,
    localparam int  M = net_msg_nbits(P, O, S)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cur_sd,
    input  logic         tx_val,
    output logic         tx_rdy,
    input  logic [S-1:0] tx_dest,
    input  logic [O-1:0] tx_opaque,
    input  logic [P-1:0] tx_payload,
    output logic         net_in_val,
    input  logic         net_in_rdy,
    output logic [M-1:0] net_in_msg,
    output logic         net_in_sd,
    input  logic         net_out_val,
    output logic         net_out_rdy,
    input  logic [M-1:0] net_out_msg,
    output logic         rx_val,
    input  logic         rx_rdy,
    output logic [S-1:0] rx_src,
    output logic [O-1:0] rx_opaque,
    output logic [P-1:0] rx_payload,
    output logic         err_misroute
`ifdef PLAB4_NET_SD_TERMINAL_STATS_EN
    ,
    output logic [15:0]  stat_tx_cnt,
    output logic [15:0]  stat_rx_cnt
`endif
);

    localparam int QW       = P + O + S;
    localparam int DEST_LSB = net_msg_dest_lsb(P, O, S);

    logic         tx_full_q, tx_full_d;
    logic [M-1:0] tx_msg_q, tx_msg_d;
    logic         err_q, err_d;
    logic         tx_go, tx_drain, rx_go, rx_hit, rx_full, rx_empty;
    logic [QW-1:0] rx_head;

    // Reset forces the ready outputs low even though the state is already clear
    assign tx_rdy      = reset & (!tx_full_q | net_in_rdy);
    assign tx_go       = tx_val & tx_rdy;
    assign tx_drain    = tx_full_q & net_in_rdy;
    assign net_in_val  = tx_full_q;
    assign net_in_msg  = tx_msg_q;
    assign net_in_sd   = p_sd;

    // Readiness depends only on our own phase and our own queue, never on rx_rdy
    assign net_out_rdy = reset & (cur_sd == p_sd) & !rx_full;
    assign rx_go       = net_out_val & net_out_rdy;
    assign rx_hit      = net_out_msg[DEST_LSB +: S] == S'(p_term_id);

    assign rx_val      = !rx_empty;
    assign {rx_src, rx_opaque, rx_payload} = rx_head;
    assign err_misroute = err_q;

    // TX register reloads on accept, empties on drain without accept
    always_comb begin
        tx_full_d = tx_go | (tx_full_q & !tx_drain);
        tx_msg_d  = tx_go ? {tx_dest, S'(p_term_id), tx_opaque, tx_payload} : tx_msg_q;
        err_d     = err_q | (rx_go & !rx_hit);
    end

    // Control flags with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_full_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tx_full_q <= tx_full_d;
            err_q     <= err_d;
        end
    end

    // Message data is not reset; it only matters while tx_full_q is set
    always_ff @(posedge clk) begin
        tx_msg_q <= tx_msg_d;
    end

    plab4_net_sd_rx_queue #(
        .p_nbits (QW),
        .p_depth (p_rx_depth)
    ) u_rx_queue (
        .clk        (clk),
        .reset      (reset),
        .enq_val_i  (rx_go & rx_hit),
        .enq_data_i (net_out_msg[QW-1:0]),
        .deq_rdy_i  (rx_rdy),
        .deq_data_o (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

`ifdef PLAB4_NET_SD_TERMINAL_STATS_EN
    logic [15:0] stx_q, stx_d, srx_q, srx_d;

    // Saturating injection and good-reception counters
    always_comb begin
        stx_d = (tx_drain && stx_q != 16'hFFFF) ? stx_q + 16'd1 : stx_q;
        srx_d = (rx_go && rx_hit && srx_q != 16'hFFFF) ? srx_q + 16'd1 : srx_q;
    end

    // Counters clear with reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stx_q <= '0;
            srx_q <= '0;
        end else begin
            stx_q <= stx_d;
            srx_q <= srx_d;
        end
    end

    assign stat_tx_cnt = stx_q;
    assign stat_rx_cnt = srx_q;
`endif

endmodule

// File: tb/tb_plab4_net_sd_terminal.sv
// tb_plab4_net_sd_terminal: directed and random checks against a queue-based reference model
module tb_plab4_net_sd_terminal;

    localparam int   TID   = 3;
    localparam logic SD    = 1'b1;
    localparam int   DEPTH = 2;

    logic        clk = 0, reset = 1, cur_sd = 0;
    logic        tx_val = 0, net_in_rdy = 0, net_out_val = 0, rx_rdy = 0;
    logic [2:0]  tx_dest = 0, tx_opaque = 0;
    logic [31:0] tx_payload = 0;
    logic [40:0] net_out_msg = 0;
    logic        tx_rdy, net_in_val, net_in_sd, net_out_rdy, rx_val, err_misroute;
    logic [40:0] net_in_msg;
    logic [2:0]  rx_src, rx_opaque;
    logic [31:0] rx_payload;
`ifdef PLAB4_NET_SD_TERMINAL_STATS_EN
    logic [15:0] stat_tx_cnt, stat_rx_cnt;
`endif

    logic [40:0] txq[$];
    logic [37:0] rxq[$];
    logic        err_m = 0;
    int          checks = 0, errors = 0, dut_rx_acc = 0, ntx = 0, nrx = 0;
    logic [40:0] exp_single;

    always #5 clk = ~clk;

    plab4_net_sd_terminal #(
        .p_payload_nbits (32), .p_opaque_nbits (3), .p_srcdest_nbits (3),
        .p_term_id (TID), .p_sd (SD), .p_rx_depth (DEPTH)
    ) dut (
        .clk (clk), .reset (reset), .cur_sd (cur_sd),
        .tx_val (tx_val), .tx_rdy (tx_rdy), .tx_dest (tx_dest),
        .tx_opaque (tx_opaque), .tx_payload (tx_payload),
        .net_in_val (net_in_val), .net_in_rdy (net_in_rdy),
        .net_in_msg (net_in_msg), .net_in_sd (net_in_sd),
        .net_out_val (net_out_val), .net_out_rdy (net_out_rdy), .net_out_msg (net_out_msg),
        .rx_val (rx_val), .rx_rdy (rx_rdy), .rx_src (rx_src),
        .rx_opaque (rx_opaque), .rx_payload (rx_payload),
        .err_misroute (err_misroute)
`ifdef PLAB4_NET_SD_TERMINAL_STATS_EN
        , .stat_tx_cnt (stat_tx_cnt), .stat_rx_cnt (stat_rx_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs against the model, advance the model, move to next negedge
    task automatic cycle();
        bit exp_tr, exp_or, acc, drn, enq, deq;
        #1;
        exp_tr = txq.size() == 0 || net_in_rdy;
        exp_or = cur_sd == SD && rxq.size() < DEPTH;
        chk("tx_rdy", 64'(tx_rdy), 64'(exp_tr));
        chk("net_out_rdy", 64'(net_out_rdy), 64'(exp_or));
        chk("net_in_val", 64'(net_in_val), 64'(txq.size() != 0));
        if (txq.size() != 0) chk("net_in_msg", 64'(net_in_msg), 64'(txq[0]));
        chk("rx_val", 64'(rx_val), 64'(rxq.size() != 0));
        if (rxq.size() != 0) chk("rx_head", 64'({rx_src, rx_opaque, rx_payload}), 64'(rxq[0]));
        chk("err_misroute", 64'(err_misroute), 64'(err_m));
`ifdef PLAB4_NET_SD_TERMINAL_STATS_EN
        chk("stat_tx_cnt", 64'(stat_tx_cnt), 64'(ntx > 65535 ? 65535 : ntx));
        chk("stat_rx_cnt", 64'(stat_rx_cnt), 64'(nrx > 65535 ? 65535 : nrx));
`endif
        if (net_out_val && net_out_rdy) dut_rx_acc++;
        acc = tx_val && exp_tr;
        drn = txq.size() != 0 && net_in_rdy;
        enq = net_out_val && exp_or;
        deq = rxq.size() != 0 && rx_rdy;
        if (drn) begin txq.delete(0); ntx++; end
        if (acc) txq.push_back({tx_dest, 3'(TID), tx_opaque, tx_payload});
        if (deq) rxq.delete(0);
        if (enq) begin
            if (net_out_msg[40:38] == 3'(TID)) begin rxq.push_back(net_out_msg[37:0]); nrx++; end
            else err_m = 1;
        end
        @(negedge clk);
        cur_sd = ~cur_sd;
    endtask

    function automatic logic [40:0] rmsg(input logic [2:0] dest);
        return {dest, 3'($urandom), 3'($urandom), 32'($urandom)};
    endfunction

    initial begin
        // Power-on reset
        #2 reset = 0;
        #1;
        chk("rst_tx_rdy", 64'(tx_rdy), 0);
        chk("rst_net_in_val", 64'(net_in_val), 0);
        chk("rst_rx_val", 64'(rx_val), 0);
        chk("rst_err", 64'(err_misroute), 0);
        @(negedge clk); @(negedge clk);
        reset = 1;

        // TX single
        net_in_rdy = 1; tx_val = 1; tx_dest = 5; tx_opaque = 1; tx_payload = 32'hDEADBEEF;
        cycle();
        tx_val = 0;
        exp_single = {3'd5, 3'(TID), 3'd1, 32'hDEADBEEF};
        #1;
        chk("tx_single_msg", 64'(net_in_msg), 64'(exp_single));
        chk("tx_single_val", 64'(net_in_val), 1);
        chk("net_in_sd", 64'(net_in_sd), 64'(SD));
        cycle();

        // TX backpressure
        net_in_rdy = 0; tx_val = 1; tx_dest = 1; tx_payload = 32'h1111_0001;
        cycle();
        tx_payload = 32'h2222_0002;
        cycle();
        cycle();
        net_in_rdy = 1;
        cycle();
        tx_val = 0;
        repeat (3) cycle();

        // Random TX
        for (int i = 0; i < 60; i++) begin
            tx_val = 1'($urandom); net_in_rdy = 1'($urandom);
            tx_dest = 3'($urandom); tx_opaque = 3'($urandom); tx_payload = $urandom;
            cycle();
        end
        tx_val = 0; net_in_rdy = 1;
        repeat (2) cycle();

        // RX domain gating
        rx_rdy = 1; net_out_val = 1; dut_rx_acc = 0;
        for (int i = 0; i < 8; i++) begin
            net_out_msg = rmsg(3'(TID));
            cycle();
        end
        chk("rx_gating_cnt", 64'(dut_rx_acc), 4);
        net_out_val = 0;
        repeat (2) cycle();

        // RX full
        rx_rdy = 0; net_out_val = 1; dut_rx_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (net_out_val && net_out_rdy) net_out_msg = rmsg(3'(TID));
            cycle();
        end
        chk("rx_full_cnt", 64'(dut_rx_acc), 2);
        rx_rdy = 1;
        cycle();
        rx_rdy = 0;
        repeat (3) cycle();
        chk("rx_full_third", 64'(dut_rx_acc), 3);
        net_out_val = 0; rx_rdy = 1;
        repeat (4) cycle();

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            tx_val = 1'($urandom); net_in_rdy = 1'($urandom);
            tx_dest = 3'($urandom); tx_opaque = 3'($urandom); tx_payload = $urandom;
            net_out_val = 1'($urandom); rx_rdy = 1'($urandom);
            net_out_msg = rmsg(3'(TID));
            cycle();
        end
        tx_val = 0; net_in_rdy = 1; net_out_val = 0; rx_rdy = 1;
        repeat (4) cycle();

        // Misroute
        net_out_val = 1; net_out_msg = rmsg(3'd4);
        repeat (2) cycle();
        net_out_val = 0;
        repeat (3) cycle();
        #1;
        chk("misroute_sticky", 64'(err_misroute), 1);
        chk("misroute_no_rx", 64'(rx_val), 0);
        @(negedge clk); cur_sd = ~cur_sd;

        // Reset mid-flight
        net_in_rdy = 0; tx_val = 1; tx_payload = 32'hCAFE_0001;
        cycle();
        tx_val = 0; rx_rdy = 0; net_out_val = 1; net_out_msg = rmsg(3'(TID));
        repeat (2) cycle();
        net_out_val = 0;
        cycle();
        #1;
        chk("pre_rst_tx_full", 64'(net_in_val), 1);
        chk("pre_rst_rx_val", 64'(rx_val), 1);
        #2 reset = 0;
        #1;
        chk("mid_rst_net_in_val", 64'(net_in_val), 0);
        chk("mid_rst_rx_val", 64'(rx_val), 0);
        chk("mid_rst_err", 64'(err_misroute), 0);
        chk("mid_rst_tx_rdy", 64'(tx_rdy), 0);
        chk("mid_rst_out_rdy", 64'(net_out_rdy), 0);
        txq.delete(); rxq.delete(); err_m = 0; ntx = 0; nrx = 0;
        @(negedge clk); cur_sd = ~cur_sd;
        @(negedge clk); cur_sd = ~cur_sd;
        reset = 1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
